// File: rtl/toy_ldu_pipe.sv
// Pipelined load unit: effective-address generation, legality/alignment checks,
// registered memory request, in-order tracking FIFO and writeback extraction.
// Faulting loads skip memory and retire in order with m_wb_err set.
module toy_ldu_pipe #(
   parameter int XLEN      = 32,
   parameter int BUS_W     = 64,
   parameter int TAG_W     = 8,
   parameter int RIDX_W    = 5,
   parameter int OST_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_load_vld,
   output logic                 s_load_rdy,
   input  logic [XLEN-1:0]      s_rs1_val,
   input  logic [XLEN-1:0]      s_imm,
   input  logic [2:0]           s_funct3,
   input  logic [RIDX_W-1:0]    s_rd,
   input  logic                 s_rd_en,
   input  logic [TAG_W-1:0]     s_lsid,
   output logic                 mem_req_vld,
   input  logic                 mem_req_rdy,
   output logic [XLEN-1:0]      mem_req_addr,
   output logic [BUS_W/8-1:0]   mem_req_strb,
   input  logic                 mem_rsp_vld,
   output logic                 mem_rsp_rdy,
   input  logic [BUS_W-1:0]     mem_rsp_data,
   output logic                 m_wb_vld,
   input  logic                 m_wb_rdy,
   output logic [RIDX_W-1:0]    m_wb_rd,
   output logic                 m_wb_rd_en,
   output logic [XLEN-1:0]      m_wb_data,
   output logic [TAG_W-1:0]     m_wb_lsid,
   output logic                 m_wb_err
);

   localparam int NBYTES = BUS_W / 8;
   localparam int OFF_W  = $clog2(NBYTES);
   localparam int PTR_W  = $clog2(OST_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam bit IS64   = (XLEN == 64);

   typedef struct packed {
      logic [TAG_W-1:0]  lsid;
      logic [RIDX_W-1:0] rd;
      logic              rd_en;
      logic [2:0]        funct3;
      logic [OFF_W-1:0]  off;
      logic              err;
   } ost_t;

   logic [XLEN-1:0]   ea;
   logic [OFF_W-1:0]  off_new;
   logic [1:0]        size;
   logic              legal;
   logic              misal;
   logic              err_new;
   logic [NBYTES-1:0] size_mask;
   logic [NBYTES-1:0] strb_new;
   logic              push;
   logic              pop;
   logic              not_empty;
   logic              wb_free;
   logic [CNT_W-1:0]  cnt;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   ost_t              ost_q [OST_DEPTH];
   ost_t              entry_new;
   ost_t              head;
   logic [XLEN-1:0]   raw;
   logic [XLEN-1:0]   ext_mask;
   logic              ext_sign;
   logic [XLEN-1:0]   ext_data;

   assign ea      = s_rs1_val + s_imm;
   assign off_new = ea[OFF_W-1:0];

   // Decode access size and legality from funct3; LD/LWU only exist on a 64-bit core.
   always_comb begin
      legal = 1'b1;
      size  = 2'd0;
      case (s_funct3)
         3'b000, 3'b100: size = 2'd0;
         3'b001, 3'b101: size = 2'd1;
         3'b010:         size = 2'd2;
         3'b110: begin
            size  = 2'd2;
            legal = IS64;
         end
         3'b011: begin
            size  = 2'd3;
            legal = IS64;
         end
         default:        legal = 1'b0;
      endcase
   end

   // Natural alignment check and byte-lane mask for the access size.
   always_comb begin
      case (size)
         2'd0: begin
            misal     = 1'b0;
            size_mask = NBYTES'(8'h01);
         end
         2'd1: begin
            misal     = ea[0];
            size_mask = NBYTES'(8'h03);
         end
         2'd2: begin
            misal     = |ea[1:0];
            size_mask = NBYTES'(8'h0F);
         end
         default: begin
            misal     = |ea[2:0];
            size_mask = NBYTES'(8'hFF);
         end
      endcase
   end

   assign err_new  = ~legal | misal;
   assign strb_new = size_mask << off_new;

   assign entry_new.lsid   = s_lsid;
   assign entry_new.rd     = s_rd;
   assign entry_new.rd_en  = s_rd_en;
   assign entry_new.funct3 = s_funct3;
   assign entry_new.off    = off_new;
   assign entry_new.err    = err_new;

   // A full FIFO blocks issue even if the head pops this cycle, keeping the ready path short.
   assign s_load_rdy = (cnt < CNT_W'(OST_DEPTH)) & (~mem_req_vld | mem_req_rdy);
   assign push       = s_load_vld & s_load_rdy;

   assign head        = ost_q[rd_ptr];
   assign not_empty   = (cnt != '0);
   assign wb_free     = ~m_wb_vld | m_wb_rdy;
   assign mem_rsp_rdy = not_empty & ~head.err & wb_free;
   assign pop         = not_empty & wb_free & (head.err | mem_rsp_vld);

   // Request register: loaded only for legal loads, held until the bus takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req_vld  <= 1'b0;
         mem_req_addr <= '0;
         mem_req_strb <= '0;
      end else if (push & ~err_new) begin
         mem_req_vld  <= 1'b1;
         mem_req_addr <= ea;
         mem_req_strb <= strb_new;
      end else if (mem_req_rdy) begin
         mem_req_vld  <= 1'b0;
      end
   end

   // Tracking FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         ost_q[wr_ptr] <= entry_new;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign raw = XLEN'(mem_rsp_data >> {head.off, 3'b000});

   // Sign/zero extension of the lane-aligned response by the head's load type.
   always_comb begin
      ext_mask = '1;
      ext_sign = 1'b0;
      case (head.funct3)
         3'b000: begin
            ext_mask = XLEN'(64'h0000_0000_0000_00FF);
            ext_sign = raw[7];
         end
         3'b001: begin
            ext_mask = XLEN'(64'h0000_0000_0000_FFFF);
            ext_sign = raw[15];
         end
         3'b010: begin
            ext_mask = XLEN'(64'h0000_0000_FFFF_FFFF);
            ext_sign = raw[31];
         end
         3'b100:  ext_mask = XLEN'(64'h0000_0000_0000_00FF);
         3'b101:  ext_mask = XLEN'(64'h0000_0000_0000_FFFF);
         3'b110:  ext_mask = XLEN'(64'h0000_0000_FFFF_FFFF);
         default: ext_mask = '1;
      endcase
      ext_data = (raw & ext_mask) | (ext_sign ? ~ext_mask : '0);
   end

   // Writeback register: loads on every head pop, holds payload while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_wb_vld   <= 1'b0;
         m_wb_rd    <= '0;
         m_wb_rd_en <= 1'b0;
         m_wb_data  <= '0;
         m_wb_lsid  <= '0;
         m_wb_err   <= 1'b0;
      end else if (pop) begin
         m_wb_vld   <= 1'b1;
         m_wb_rd    <= head.rd;
         m_wb_rd_en <= head.rd_en & ~head.err;
         m_wb_data  <= head.err ? '0 : ext_data;
         m_wb_lsid  <= head.lsid;
         m_wb_err   <= head.err;
      end else if (m_wb_rdy) begin
         m_wb_vld   <= 1'b0;
      end
   end

   // A response with nothing legal to match it is a memory-side protocol error.
   a_rsp_protocol: assert property (@(posedge clk) disable iff (rst)
      mem_rsp_vld |-> (not_empty & ~head.err));

endmodule

// File: tb/tb_toy_ldu_pipe.sv
// Bench for toy_ldu_pipe: vector table plus corner-case sequences, with an
// in-order memory model and scoreboard queues for requests and writebacks.
module tb_toy_ldu_pipe;

   localparam int XLEN      = 32;
   localparam int BUS_W     = 64;
   localparam int TAG_W     = 8;
   localparam int RIDX_W    = 5;
   localparam int OST_DEPTH = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                s_load_vld;
   logic                s_load_rdy;
   logic [XLEN-1:0]     s_rs1_val;
   logic [XLEN-1:0]     s_imm;
   logic [2:0]          s_funct3;
   logic [RIDX_W-1:0]   s_rd;
   logic                s_rd_en;
   logic [TAG_W-1:0]    s_lsid;
   logic                mem_req_vld;
   logic                mem_req_rdy;
   logic [XLEN-1:0]     mem_req_addr;
   logic [BUS_W/8-1:0]  mem_req_strb;
   logic                mem_rsp_vld;
   logic                mem_rsp_rdy;
   logic [BUS_W-1:0]    mem_rsp_data;
   logic                m_wb_vld;
   logic                m_wb_rdy;
   logic [RIDX_W-1:0]   m_wb_rd;
   logic                m_wb_rd_en;
   logic [XLEN-1:0]     m_wb_data;
   logic [TAG_W-1:0]    m_wb_lsid;
   logic                m_wb_err;

   always #5 clk = ~clk;

   toy_ldu_pipe #(
      .XLEN(XLEN), .BUS_W(BUS_W), .TAG_W(TAG_W), .RIDX_W(RIDX_W), .OST_DEPTH(OST_DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .s_load_vld(s_load_vld), .s_load_rdy(s_load_rdy),
      .s_rs1_val(s_rs1_val), .s_imm(s_imm), .s_funct3(s_funct3),
      .s_rd(s_rd), .s_rd_en(s_rd_en), .s_lsid(s_lsid),
      .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy),
      .mem_req_addr(mem_req_addr), .mem_req_strb(mem_req_strb),
      .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(mem_rsp_rdy), .mem_rsp_data(mem_rsp_data),
      .m_wb_vld(m_wb_vld), .m_wb_rdy(m_wb_rdy), .m_wb_rd(m_wb_rd), .m_wb_rd_en(m_wb_rd_en),
      .m_wb_data(m_wb_data), .m_wb_lsid(m_wb_lsid), .m_wb_err(m_wb_err)
   );

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] rs1;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        rd_en;
      logic [7:0]  lsid;
      logic [63:0] bus;
      logic [7:0]  strb;
      logic [31:0] data;
      logic        err;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  strb;
   } req_t;

   typedef struct {
      logic [4:0]  rd;
      logic        rd_en;
      logic [31:0] data;
      logic [7:0]  lsid;
      logic        err;
   } wb_t;

   req_t        exp_req_q [$];
   wb_t         exp_wb_q [$];
   logic [63:0] rsp_data_q [$];
   req_t        mr;
   wb_t         mw;
   int          pending;
   int          rsp_fires;
   int          pass_cnt;
   int          total_cnt;
   logic        rsp_en;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] imm,
                               input logic [7:0] lsid, input logic rd_en, input logic [63:0] bus,
                               input logic [7:0] strb, input logic [31:0] data, input logic err);
      vec_t v;
      v.f3 = f3; v.rs1 = rs1; v.imm = imm; v.rd = lsid[4:0]; v.rd_en = rd_en; v.lsid = lsid;
      v.bus = bus; v.strb = strb; v.data = data; v.err = err;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      s_funct3 = v.f3; s_rs1_val = v.rs1; s_imm = v.imm;
      s_rd = v.rd; s_rd_en = v.rd_en; s_lsid = v.lsid;
   endtask

   task automatic push_exp(input vec_t v);
      req_t r;
      wb_t  w;
      if (!v.err) begin
         r.addr = v.rs1 + v.imm;
         r.strb = v.strb;
         exp_req_q.push_back(r);
         rsp_data_q.push_back(v.bus);
      end
      w.rd = v.rd; w.rd_en = v.rd_en & ~v.err; w.data = v.err ? 32'h0 : v.data;
      w.lsid = v.lsid; w.err = v.err;
      exp_wb_q.push_back(w);
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic issue(input vec_t v);
      int n = 0;
      drive(v);
      s_load_vld = 1'b1;
      @(negedge clk); #1;
      while (!s_load_rdy && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      if (!s_load_rdy) check("issue_timeout", 64'(s_load_rdy), 64'd1);
      else push_exp(v);
      @(posedge clk); #1;
      s_load_vld = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_wb_q.size() != 0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_wb_left", 64'(exp_wb_q.size()), 64'd0);
   endtask

   // Memory model and scoreboard: handshakes judged at negedge, responses driven at posedge+2.
   always begin
      @(negedge clk);
      if (!rst) begin
         if (mem_req_vld && mem_req_rdy) begin
            if (exp_req_q.size() == 0) begin
               check("req_unexpected", 64'(mem_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               mr = exp_req_q.pop_front();
               check("req_addr", 64'(mem_req_addr), 64'(mr.addr));
               check("req_strb", 64'(mem_req_strb), 64'(mr.strb));
            end
            pending++;
         end
         if (mem_rsp_vld && mem_rsp_rdy) begin
            pending--;
            if (rsp_data_q.size() != 0) void'(rsp_data_q.pop_front());
            rsp_fires++;
         end
         if (m_wb_vld && m_wb_rdy) begin
            if (exp_wb_q.size() == 0) begin
               check("wb_unexpected", 64'(m_wb_lsid), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               mw = exp_wb_q.pop_front();
               check("wb_data", 64'(m_wb_data), 64'(mw.data));
               check("wb_meta", 64'({m_wb_rd, m_wb_rd_en, m_wb_lsid, m_wb_err}),
                     64'({mw.rd, mw.rd_en, mw.lsid, mw.err}));
            end
         end
      end
      @(posedge clk); #2;
      mem_rsp_vld  = rsp_en && (pending > 0) && (rsp_data_q.size() > 0);
      mem_rsp_data = (rsp_data_q.size() > 0) ? rsp_data_q[0] : 64'h0;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs [14];
      vec_t v;
      int   n;
      int   f0;

      vecs[0]  = mk(3'b000, 32'h1000, 32'd3, 8'h01, 1'b1, 64'h0123_4567_80AB_CDEF, 8'h08, 32'hFFFF_FF80, 1'b0);
      vecs[1]  = mk(3'b101, 32'h1000, 32'd6, 8'h02, 1'b1, 64'h8001_0000_0000_0000, 8'hC0, 32'h0000_8001, 1'b0);
      vecs[2]  = mk(3'b010, 32'h1000, 32'd2, 8'h03, 1'b1, 64'h0, 8'h00, 32'h0, 1'b1);
      vecs[3]  = mk(3'b010, 32'h1008, 32'hFFFF_FFFC, 8'h04, 1'b1, 64'hDEAD_BEEF_0000_0000, 8'hF0, 32'hDEAD_BEEF, 1'b0);
      vecs[4]  = mk(3'b001, 32'h2000, 32'd2, 8'h05, 1'b1, 64'h0000_0000_8234_0000, 8'h0C, 32'hFFFF_8234, 1'b0);
      vecs[5]  = mk(3'b100, 32'h3000, 32'd7, 8'h06, 1'b1, 64'hF500_0000_0000_0000, 8'h80, 32'h0000_00F5, 1'b0);
      vecs[6]  = mk(3'b011, 32'h1000, 32'd0, 8'h07, 1'b1, 64'h0, 8'h00, 32'h0, 1'b1);
      vecs[7]  = mk(3'b110, 32'h1000, 32'd0, 8'h08, 1'b1, 64'h0, 8'h00, 32'h0, 1'b1);
      vecs[8]  = mk(3'b111, 32'h1000, 32'd0, 8'h09, 1'b1, 64'h0, 8'h00, 32'h0, 1'b1);
      vecs[9]  = mk(3'b001, 32'h1000, 32'd1, 8'h0A, 1'b1, 64'h0, 8'h00, 32'h0, 1'b1);
      vecs[10] = mk(3'b010, 32'hFFFF_FFFC, 32'd8, 8'h0B, 1'b1, 64'h7FFF_FFFF_0000_0000, 8'hF0, 32'h7FFF_FFFF, 1'b0);
      vecs[11] = mk(3'b000, 32'h10, 32'd0, 8'h0C, 1'b0, 64'h1111_1111_1111_117F, 8'h01, 32'h0000_007F, 1'b0);
      vecs[12] = mk(3'b101, 32'h20, 32'd0, 8'h0D, 1'b1, 64'h0000_0000_0000_FFFF, 8'h03, 32'h0000_FFFF, 1'b0);
      vecs[13] = mk(3'b000, 32'h1000, 32'd5, 8'h0E, 1'b1, 64'h0000_F600_0000_0000, 8'h20, 32'hFFFF_FFF6, 1'b0);

      rst = 1'b1; s_load_vld = 1'b0; s_rs1_val = '0; s_imm = '0; s_funct3 = '0;
      s_rd = '0; s_rd_en = 1'b0; s_lsid = '0; mem_req_rdy = 1'b1; mem_rsp_vld = 1'b0;
      mem_rsp_data = '0; m_wb_rdy = 1'b1; rsp_en = 1'b1; pending = 0; rsp_fires = 0;
      pass_cnt = 0; total_cnt = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk); #1;
      check("rst_mem_req_vld", 64'(mem_req_vld), 64'd0);
      check("rst_m_wb_vld", 64'(m_wb_vld), 64'd0);
      check("rst_mem_rsp_rdy", 64'(mem_rsp_rdy), 64'd0);
      check("rst_s_load_rdy", 64'(s_load_rdy), 64'd1);
      check("rst_wb_data", 64'(m_wb_data), 64'd0);
      check("rst_req_strb", 64'(mem_req_strb), 64'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) issue(vecs[i]);
      drain();

      // Outstanding limit: four loads in flight with no responses, fifth must wait.
      rsp_en = 1'b0;
      for (int i = 0; i < 4; i++)
         issue(mk(3'b010, 32'h4000 + 32'(16 * i), 32'd0, 8'h40 + 8'(i), 1'b1,
                  64'hA000_0000 + 64'(i), 8'h0F, 32'hA000_0000 + 32'(i), 1'b0));
      v = mk(3'b010, 32'h4040, 32'd0, 8'h44, 1'b1, 64'h0000_0000_8000_0004, 8'h0F, 32'h8000_0004, 1'b0);
      drive(v);
      s_load_vld = 1'b1;
      repeat (3) begin
         @(negedge clk); #1;
         check("ost_full_rdy", 64'(s_load_rdy), 64'd0);
      end
      @(posedge clk); #1;
      f0 = rsp_fires;
      rsp_en = 1'b1;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (rsp_fires == f0 && n < 20);
      check("one_rsp_seen", 64'(rsp_fires - f0), 64'd1);
      check("no_pop_bypass", 64'(s_load_rdy), 64'd0);
      @(posedge clk); #1;
      rsp_en = 1'b0;
      @(negedge clk); #1;
      check("rdy_after_pop", 64'(s_load_rdy), 64'd1);
      if (s_load_rdy) push_exp(v);
      @(posedge clk); #1;
      s_load_vld = 1'b0;
      rsp_en = 1'b1;
      drain();

      // Writeback stall with a response waiting behind it.
      m_wb_rdy = 1'b0;
      issue(mk(3'b100, 32'h5000, 32'd1, 8'h51, 1'b1, 64'h0000_0000_0000_9C00, 8'h02, 32'h0000_009C, 1'b0));
      issue(mk(3'b001, 32'h5000, 32'd4, 8'h52, 1'b1, 64'h0000_7123_0000_0000, 8'h30, 32'h0000_7123, 1'b0));
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!m_wb_vld && n < 20);
      check("stall_wb_vld", 64'(m_wb_vld), 64'd1);
      repeat (3) begin
         @(posedge clk); #1;
         @(negedge clk); #1;
         check("stall_rsp_rdy", 64'(mem_rsp_rdy), 64'd0);
         check("stall_wb_data", 64'(m_wb_data), 64'h9C);
         check("stall_wb_lsid", 64'(m_wb_lsid), 64'h51);
      end
      check("stall_rsp_pending", 64'(mem_rsp_vld), 64'd1);
      @(posedge clk); #1;
      m_wb_rdy = 1'b1;
      drain();

      // Request backpressure: payload must hold until the bus accepts.
      mem_req_rdy = 1'b0;
      issue(mk(3'b010, 32'h6000, 32'd0, 8'h60, 1'b1, 64'h0000_0000_1234_5678, 8'h0F, 32'h1234_5678, 1'b0));
      repeat (3) begin
         @(negedge clk); #1;
         check("reqhold_vld", 64'(mem_req_vld), 64'd1);
         check("reqhold_addr", 64'(mem_req_addr), 64'h6000);
         check("reqhold_rdy", 64'(s_load_rdy), 64'd0);
         @(posedge clk); #1;
      end
      mem_req_rdy = 1'b1;
      drain();

      // Reset with two loads outstanding; memory side is reset alongside.
      rsp_en = 1'b0;
      issue(mk(3'b010, 32'h7000, 32'd0, 8'h70, 1'b1, 64'h0, 8'h0F, 32'h0, 1'b0));
      issue(mk(3'b010, 32'h7004, 32'd0, 8'h71, 1'b1, 64'h0, 8'hF0, 32'h0, 1'b0));
      rst = 1'b1;
      exp_req_q.delete();
      exp_wb_q.delete();
      rsp_data_q.delete();
      pending = 0;
      mem_rsp_vld = 1'b0;
      @(negedge clk); #1;
      check("mid_rst_req_vld", 64'(mem_req_vld), 64'd0);
      check("mid_rst_wb_vld", 64'(m_wb_vld), 64'd0);
      check("mid_rst_load_rdy", 64'(s_load_rdy), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      rsp_en = 1'b1;
      issue(mk(3'b101, 32'h7100, 32'd2, 8'h72, 1'b1, 64'h0000_0000_ABCD_0000, 8'h0C, 32'h0000_ABCD, 1'b0));
      drain();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
